// File: rtl/vec_lane_sched.sv
// Four-lane vector ALU sequencer: latches the op config, strobes the active lanes,
// captures each lane result on done and drains the results round-robin to the register file.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; config outputs hold the last operation
// S_RUN   | lanes running; results captured and written back as they land
// S_DRAIN | every lane has finished; emptying the holding buffers
// S_FIN   | one-cycle op_done pulse, then back to S_IDLE
module vec_lane_sched #(
  parameter int VLEN   = 128,
  parameter int NLANES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  nb_lanes_in,
  input  logic [5:0]  opcode_in,
  input  logic [2:0]  vsew_in,
  input  logic [2:0]  op_type_in,
  output logic [1:0]  nb_lanes,
  output logic [5:0]  opcode,
  output logic [2:0]  vsew,
  output logic [2:0]  op_type,
  output logic        run0,
  output logic        run1,
  output logic        run2,
  output logic        run3,
  input  logic        done0,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  input  logic [63:0] vd0,
  input  logic [63:0] vd1,
  input  logic [63:0] vd2,
  input  logic [63:0] vd3,
  input  logic [9:0]  regi0,
  input  logic [9:0]  regi1,
  input  logic [9:0]  regi2,
  input  logic [9:0]  regi3,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [9:0]  wb_idx,
  output logic [1:0]  wb_lane,
  output logic        busy,
  output logic        op_done
);

  // An unsupported geometry leaves the write-back port permanently idle.
  localparam bit CFG_OK = (NLANES == 4) && (VLEN >= 64);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t      r_state;
  logic [3:0]  r_pending;
  logic [3:0]  r_hvalid;
  logic [63:0] r_hdata [4];
  logic [9:0]  r_hidx  [4];
  logic [1:0]  r_rr_ptr;
  logic        r_locked;
  logic [1:0]  r_lock_lane;
  logic [1:0]  r_nb_lanes;
  logic [5:0]  r_opcode;
  logic [2:0]  r_vsew;
  logic [2:0]  r_op_type;

  logic [3:0]  w_done;
  logic [63:0] w_vd   [4];
  logic [9:0]  w_regi [4];
  logic [3:0]  w_start_mask;
  logic [3:0]  w_capture;
  logic [3:0]  w_clr;
  logic [3:0]  w_pending_nx;
  logic [3:0]  w_hvalid_nx;
  logic        w_active;
  logic        w_wb_valid;
  logic        w_hs;
  logic [1:0]  w_probe;
  logic [1:0]  w_rr_grant;
  logic [1:0]  w_grant;

  assign w_done    = {done3, done2, done1, done0};
  assign w_vd[0]   = vd0;
  assign w_vd[1]   = vd1;
  assign w_vd[2]   = vd2;
  assign w_vd[3]   = vd3;
  assign w_regi[0] = regi0;
  assign w_regi[1] = regi1;
  assign w_regi[2] = regi2;
  assign w_regi[3] = regi3;

  always_comb begin
    w_start_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_start_mask[i] = (2'(i) <= nb_lanes_in);
    end
  end

  // Scan from the farthest lane back toward rr_ptr so the nearest valid lane wins.
  always_comb begin
    w_rr_grant = r_rr_ptr;
    w_probe    = '0;
    for (int k = 3; k >= 0; k--) begin
      w_probe = r_rr_ptr + 2'(k);
      if (r_hvalid[w_probe]) w_rr_grant = w_probe;
    end
  end

  assign w_active     = CFG_OK && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_wb_valid   = w_active && (r_hvalid != 4'd0);
  assign w_grant      = r_locked ? r_lock_lane : w_rr_grant;
  assign w_hs         = w_wb_valid && wb_ready;
  assign w_capture    = (r_state == S_RUN) ? (w_done & r_pending) : 4'd0;
  assign w_clr        = w_hs ? (4'b0001 << w_grant) : 4'd0;
  assign w_pending_nx = r_pending & ~w_capture;
  assign w_hvalid_nx  = (r_hvalid & ~w_clr) | w_capture;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_hvalid    <= '0;
      r_rr_ptr    <= '0;
      r_locked    <= 1'b0;
      r_lock_lane <= '0;
      r_nb_lanes  <= '0;
      r_opcode    <= '0;
      r_vsew      <= '0;
      r_op_type   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_hdata[i] <= '0;
        r_hidx[i]  <= '0;
      end
    end else begin
      if (w_hs) r_rr_ptr <= w_grant + 2'd1;

      // Freeze the grant while the register file stalls so a newly captured lane cannot preempt it.
      if (w_hs) begin
        r_locked <= 1'b0;
      end else if (w_wb_valid) begin
        r_locked    <= 1'b1;
        r_lock_lane <= w_grant;
      end

      for (int i = 0; i < 4; i++) begin
        if (w_capture[i]) begin
          r_hdata[i] <= w_vd[i];
          r_hidx[i]  <= w_regi[i];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nb_lanes <= nb_lanes_in;
            r_opcode   <= opcode_in;
            r_vsew     <= vsew_in;
            r_op_type  <= op_type_in;
            r_pending  <= w_start_mask;
            r_hvalid   <= '0;
            r_locked   <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_pending <= w_pending_nx;
          r_hvalid  <= w_hvalid_nx;
          if (w_pending_nx == 4'd0) begin
            r_state <= (w_hvalid_nx == 4'd0) ? S_FIN : S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_hvalid <= w_hvalid_nx;
          if (w_hvalid_nx == 4'd0) r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nb_lanes = r_nb_lanes;
  assign opcode   = r_opcode;
  assign vsew     = r_vsew;
  assign op_type  = r_op_type;
  assign run0     = r_pending[0];
  assign run1     = r_pending[1];
  assign run2     = r_pending[2];
  assign run3     = r_pending[3];
  assign wb_valid = w_wb_valid;
  assign wb_data  = w_wb_valid ? r_hdata[w_grant] : 64'd0;
  assign wb_idx   = w_wb_valid ? r_hidx[w_grant]  : 10'd0;
  assign wb_lane  = w_wb_valid ? w_grant          : 2'd0;
  assign busy     = (r_state != S_IDLE);
  assign op_done  = (r_state == S_FIN);

endmodule

// File: tb/tb_vec_lane_sched.sv
// Bench for vec_lane_sched: a cycle-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized operations.
module tb_vec_lane_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  nb_lanes_in = '0;
  logic [5:0]  opcode_in = '0;
  logic [2:0]  vsew_in = '0;
  logic [2:0]  op_type_in = '0;
  logic [3:0]  t_done = '0;
  logic [63:0] t_vd [4];
  logic [9:0]  t_regi [4];
  logic        wb_ready = 1'b1;

  logic [1:0]  nb_lanes;
  logic [5:0]  opcode;
  logic [2:0]  vsew, op_type;
  logic        run0, run1, run2, run3;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [9:0]  wb_idx;
  logic [1:0]  wb_lane;
  logic        busy, op_done;

  vec_lane_sched #(.VLEN(128), .NLANES(4)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .nb_lanes_in(nb_lanes_in), .opcode_in(opcode_in), .vsew_in(vsew_in), .op_type_in(op_type_in),
    .nb_lanes(nb_lanes), .opcode(opcode), .vsew(vsew), .op_type(op_type),
    .run0(run0), .run1(run1), .run2(run2), .run3(run3),
    .done0(t_done[0]), .done1(t_done[1]), .done2(t_done[2]), .done3(t_done[3]),
    .vd0(t_vd[0]), .vd1(t_vd[1]), .vd2(t_vd[2]), .vd3(t_vd[3]),
    .regi0(t_regi[0]), .regi1(t_regi[1]), .regi2(t_regi[2]), .regi3(t_regi[3]),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_idx(wb_idx),
    .wb_lane(wb_lane), .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 lanes running, 2 draining, 3 completion pulse.
  int          m_phase;
  bit [3:0]    m_pend, m_hv;
  logic [63:0] m_hd [4];
  logic [9:0]  m_hi [4];
  int          m_rr, m_lock;
  logic [1:0]  m_nb;
  logic [5:0]  m_op;
  logic [2:0]  m_vsew, m_opt;

  function automatic int m_grant_f();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < 4; k++) if (m_hv[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return 0;
  endfunction

  function automatic bit m_valid_f();
    return ((m_phase == 1) || (m_phase == 2)) && (m_hv != 0);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_hv = 0; m_rr = 0; m_lock = -1;
    m_nb = 0; m_op = 0; m_vsew = 0; m_opt = 0;
    for (int i = 0; i < 4; i++) begin m_hd[i] = 0; m_hi[i] = 0; end
  endtask

  task automatic compare();
    int g;
    bit v;
    v = m_valid_f();
    g = m_grant_f();
    chk("busy", busy, m_phase != 0);
    chk("op_done", op_done, m_phase == 3);
    chk("run", {run3, run2, run1, run0}, m_pend);
    chk("wb_valid", wb_valid, v);
    if (v) begin
      chk("wb_lane", wb_lane, g);
      chk("wb_idx", wb_idx, m_hi[g]);
      chk("wb_data", wb_data, m_hd[g]);
    end
    chk("cfg_nb_lanes", nb_lanes, m_nb);
    chk("cfg_opcode", opcode, m_op);
    chk("cfg_vsew", vsew, m_vsew);
    chk("cfg_op_type", op_type, m_opt);
  endtask

  task automatic advance();
    int g;
    bit v;
    bit [3:0] cap;
    if (m_phase == 0) begin
      if (start) begin
        m_nb = nb_lanes_in; m_op = opcode_in; m_vsew = vsew_in; m_opt = op_type_in;
        for (int i = 0; i < 4; i++) m_pend[i] = (i <= int'(nb_lanes_in));
        m_hv = 0; m_lock = -1; m_phase = 1;
      end
    end else begin
      v = m_valid_f();
      g = m_grant_f();
      cap = (m_phase == 1) ? (t_done & m_pend) : 4'd0;
      if (v && wb_ready) begin
        m_hv[g] = 0; m_rr = (g + 1) % 4; m_lock = -1;
      end else if (v) begin
        m_lock = g;
      end
      for (int i = 0; i < 4; i++) if (cap[i]) begin m_hd[i] = t_vd[i]; m_hi[i] = t_regi[i]; end
      m_pend = m_pend & ~cap;
      m_hv = m_hv | cap;
      if (m_phase == 1) begin
        if (m_pend == 0) m_phase = (m_hv != 0) ? 2 : 3;
      end else if (m_phase == 2) begin
        if (m_hv == 0) m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  typedef struct {int cyc; int lane; logic [9:0] idx; logic [63:0] data;} hs_t;
  hs_t hs_q[$];
  int  opd_q[$];
  int  run_cnt [4];
  int  run_first [4];

  always @(negedge clk) begin
    if (!resetn) begin
      model_reset();
      compare();
    end else begin
      compare();
      if (wb_valid && wb_ready) hs_q.push_back('{cyc, int'(wb_lane), wb_idx, wb_data});
      if (op_done) opd_q.push_back(cyc);
      for (int i = 0; i < 4; i++) begin
        if ({run3, run2, run1, run0} & (4'b0001 << i)) begin
          run_cnt[i]++;
          if (run_first[i] < 0) run_first[i] = cyc;
        end
      end
      advance();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_q.delete();
    opd_q.delete();
    for (int i = 0; i < 4; i++) begin run_cnt[i] = 0; run_first[i] = -1; end
  endtask

  task automatic start_op(input logic [1:0] nb, input logic [5:0] op, input logic [2:0] vs,
                          input logic [2:0] ot, output int t);
    nb_lanes_in = nb; opcode_in = op; vsew_in = vs; op_type_in = ot;
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic set_lane(input int i, input logic [63:0] d, input logic [9:0] r);
    t_vd[i] = d;
    t_regi[i] = r;
  endtask

  // Checks the drain order, back-to-back timing and op_done position of a completed operation.
  task automatic chk_order(input string nm, input int first_lane, input int n, input int t_first);
    chk({nm, "_count"}, hs_q.size(), n);
    for (int i = 0; i < hs_q.size() && i < n; i++) begin
      chk({nm, "_lane"}, hs_q[i].lane, (first_lane + i) % 4);
      chk({nm, "_cyc"}, hs_q[i].cyc, t_first + i);
    end
    chk({nm, "_opdone_count"}, opd_q.size(), 1);
    if (opd_q.size() > 0) chk({nm, "_opdone_cyc"}, opd_q[0], t_first + n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    logic [63:0] d_a, d_b;
    for (int i = 0; i < 4; i++) begin t_vd[i] = '0; t_regi[i] = '0; end
    model_reset();
    clear_log();

    #1 resetn = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_done", op_done, 1'b0);
    chk("rst_run", {run3, run2, run1, run0}, 4'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_idx", wb_idx, 10'd0);
    chk("rst_wb_lane", wb_lane, 2'd0);
    chk("rst_cfg", {nb_lanes, opcode, vsew, op_type}, 14'd0);
    resetn = 1'b1;
    tick();

    // Simultaneous dones, rr_ptr at 0: drains 0,1,2,3 back to back.
    clear_log();
    start_op(2'd3, 6'h11, 3'd2, 3'd1, t0);
    t_done = 4'hF;
    for (int i = 0; i < 4; i++) set_lane(i, 64'h1000 + 64'(i), 10'(100 + i));
    tick();
    t_done = 4'h0;
    wait_idle(50, "simul_timeout");
    chk_order("simul", 0, 4, t0 + 2);
    if (hs_q.size() > 3) chk("simul_data3", hs_q[3].data, 64'h1003);

    // Single lane minimum path.
    clear_log();
    start_op(2'd0, 6'h05, 3'd1, 3'd2, t0);
    tick();
    tick();
    t_done = 4'b0001;
    set_lane(0, 64'hDEAD_BEEF, 10'd7);
    tick();
    t_done = 4'h0;
    wait_idle(50, "single_timeout");
    chk("single_count", hs_q.size(), 1);
    if (hs_q.size() > 0) begin
      chk("single_cyc", hs_q[0].cyc, t0 + 4);
      chk("single_lane", hs_q[0].lane, 0);
      chk("single_idx", hs_q[0].idx, 10'd7);
      chk("single_data", hs_q[0].data, 64'hDEAD_BEEF);
    end
    chk("single_opdone_count", opd_q.size(), 1);
    if (opd_q.size() > 0) chk("single_opdone_cyc", opd_q[0], t0 + 5);
    chk("single_run0_cnt", run_cnt[0], 3);
    chk("single_run0_first", run_first[0], t0 + 1);
    chk("single_run_other", run_cnt[1] + run_cnt[2] + run_cnt[3], 0);

    // Backpressure: rr_ptr is now 1, so lane 1 is granted and must hold through the stall.
    clear_log();
    wb_ready = 1'b0;
    start_op(2'd1, 6'h21, 3'd0, 3'd0, t0);
    d_a = 64'hAAAA_0000_0000_0001;
    d_b = 64'hBBBB_0000_0000_0002;
    t_done = 4'b0011;
    set_lane(0, d_a, 10'd20);
    set_lane(1, d_b, 10'd21);
    tick();
    t_done = 4'h0;
    for (int s = 0; s < 5; s++) begin
      chk("bp_valid", wb_valid, 1'b1);
      chk("bp_lane", wb_lane, 2'd1);
      chk("bp_idx", wb_idx, 10'd21);
      chk("bp_data", wb_data, d_b);
      tick();
    end
    wb_ready = 1'b1;
    wait_idle(50, "bp_timeout");
    chk("bp_count", hs_q.size(), 2);
    if (hs_q.size() > 1) begin
      chk("bp_first_lane", hs_q[0].lane, 1);
      chk("bp_first_cyc", hs_q[0].cyc, t0 + 7);
      chk("bp_second_lane", hs_q[1].lane, 0);
      chk("bp_second_data", hs_q[1].data, d_a);
      chk("bp_second_cyc", hs_q[1].cyc, t0 + 8);
    end

    // Spurious dones and a start while busy.
    clear_log();
    start_op(2'd1, 6'h2A, 3'd3, 3'd4, t0);
    t_done = 4'b0101;
    set_lane(0, 64'h0123_4567, 10'd30);
    set_lane(2, 64'h0000_0BAD, 10'd32);
    tick();
    t_done = 4'b0001;
    set_lane(0, 64'h0000_0BAD, 10'd33);
    start = 1'b1;
    nb_lanes_in = 2'd3;
    opcode_in = 6'h3F;
    tick();
    start = 1'b0;
    t_done = 4'h0;
    tick();
    tick();
    t_done = 4'b0010;
    set_lane(1, 64'h89AB_CDEF, 10'd31);
    tick();
    t_done = 4'h0;
    wait_idle(50, "spur_timeout");
    chk("spur_count", hs_q.size(), 2);
    if (hs_q.size() > 1) begin
      chk("spur_lane0", hs_q[0].lane, 0);
      chk("spur_data0", hs_q[0].data, 64'h0123_4567);
      chk("spur_lane1", hs_q[1].lane, 1);
      chk("spur_idx1", hs_q[1].idx, 10'd31);
    end
    chk("spur_opcode_kept", opcode, 6'h2A);
    chk("spur_nb_kept", nb_lanes, 2'd1);

    // Async reset in RUN with captured results waiting behind a stalled register file.
    clear_log();
    wb_ready = 1'b0;
    start_op(2'd3, 6'h15, 3'd1, 3'd1, t0);
    t_done = 4'b0011;
    tick();
    t_done = 4'h0;
    chk("ar_pre_valid", wb_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_run", {run3, run2, run1, run0}, 4'd0);
    chk("ar_wb_valid", wb_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_cfg", {nb_lanes, opcode, vsew, op_type}, 14'd0);
    tick();
    tick();
    resetn = 1'b1;
    wb_ready = 1'b1;
    tick();
    chk("ar_no_opdone", opd_q.size(), 0);
    chk("ar_no_wb", hs_q.size(), 0);

    // Fresh rr_ptr: three lanes drain 0,1,2, leaving the pointer on lane 3.
    clear_log();
    start_op(2'd2, 6'h01, 3'd0, 3'd0, t0);
    t_done = 4'b0111;
    for (int i = 0; i < 4; i++) set_lane(i, 64'h2000 + 64'(i), 10'(200 + i));
    tick();
    t_done = 4'h0;
    wait_idle(50, "post_rst_timeout");
    chk_order("post_rst", 0, 3, t0 + 2);

    // Wrap: four lanes together now drain 3,0,1,2.
    clear_log();
    start_op(2'd3, 6'h02, 3'd0, 3'd0, t0);
    t_done = 4'hF;
    tick();
    t_done = 4'h0;
    wait_idle(50, "wrap_timeout");
    chk_order("wrap", 3, 4, t0 + 2);

    // Randomized operations; the per-cycle model check carries the verdict.
    for (int op = 0; op < 30; op++) begin
      repeat ($urandom_range(0, 2)) tick();
      start_op(2'($urandom_range(0, 3)), 6'($urandom), 3'($urandom), 3'($urandom), t0);
      n = 0;
      while (busy && n < 300) begin
        t_done = 4'($urandom) & 4'($urandom);
        for (int i = 0; i < 4; i++) set_lane(i, {$urandom, $urandom}, 10'($urandom));
        wb_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        nb_lanes_in = 2'($urandom);
        opcode_in = 6'($urandom);
        tick();
        n++;
      end
      t_done = 4'h0;
      start = 1'b0;
      wb_ready = 1'b1;
      chk("rand_timeout", busy, 1'b0);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_lane_sched.md
# vec_lane_sched

Sequencing controller for the four-lane vector ALU array. It accepts one vector operation from the decode stage and latches its configuration toward the lanes. It raises the per-lane run strobes for the active lanes and captures each lane's 64-bit result and register index on its done pulse. It then drains the captured results one per cycle, round-robin, to the vector register file write port.

## Interface
- VLEN, 128: vector register width in bits; forwarded to the result index width check only.
- NLANES, 4: physical lanes; fixed at 4, and the port set below is sized for it.

- clk  in  1  system clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  operation request; sampled only in IDLE
- nb_lanes_in  in  2  active lane count minus 1 (0 → 1 lane … 3 → 4 lanes)
- opcode_in  in  6  ALU opcode
- vsew_in  in  3  element width code
- op_type_in  in  3  operand type code
- nb_lanes, opcode, vsew, op_type  out  2/6/3/3  latched configuration driven to the lanes
- run0..run3  out  1  per-lane run strobe
- done0..done3  in  1  per-lane completion pulse; vdN/regiN valid in that cycle
- vd0..vd3  in  64  lane results
- regi0..regi3  in  10  lane destination indices
- wb_valid  out  1  write-back request
- wb_ready  in  1  register-file accept
- wb_data  out  64  write-back data
- wb_idx  out  10  write-back index
- wb_lane  out  2  source lane of the current write-back
- busy  out  1  high from accepted start until op_done
- op_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- **IDLE**
  - On start=1: latch nb_lanes_in, opcode_in, vsew_in and op_type_in into the config outputs.
  - Set pending[i]=1 for every i ≤ nb_lanes_in and clear all holding valids.
  - Go to RUN.
- **RUN**
  - runN = pending[N].
  - On doneN with pending[N]=1: capture vdN and regiN into holding buffer N, set hvalid[N], clear pending[N]. runN drops the next cycle.
  - doneN with pending[N]=0 is ignored; this covers inactive lanes and second pulses. No capture occurs.
  - Simultaneous dones on several lanes are all captured in the same cycle.
  - When pending is all zero, go to DRAIN.
- **Write-back** (active in RUN and DRAIN)
  - wb_valid = OR(hvalid).
  - The grant selects the first lane with hvalid set, searching upward from rr_ptr with wrap 3→0.
  - The grant is held stable while wb_valid=1 and wb_ready=0. wb_data, wb_idx and wb_lane must not change during the stall.
  - On a handshake (wb_valid & wb_ready): clear hvalid[grant] and set rr_ptr = grant+1 mod 4.
  - A lane captured in the same cycle as a handshake becomes eligible the following cycle.
- **DRAIN**: when hvalid is all zero and no handshake is pending, go to FIN.
- **FIN**: op_done=1 for one cycle, then go to IDLE.
- busy = (state ≠ IDLE).
- start while busy=1 is ignored.
- The config outputs hold their values until the next accepted start.
- rr_ptr is not reset at start; it persists across operations.

## Timing
- Reset values:
  - All runN, wb_valid, busy and op_done are 0.
  - nb_lanes, opcode, vsew and op_type are 0.
  - wb_data, wb_idx and wb_lane are 0.
  - rr_ptr=0; state is IDLE; pending and hvalid are cleared.
- Reset asserted mid-operation aborts immediately: all outputs return to their reset values, and no op_done is issued.
- start accepted in cycle T: busy and runN are high from T+1.
- doneN in cycle D: runN is low from D+1, and lane N is eligible for write-back from D+1.
- Minimum latency, single lane with done at T+1 and wb_ready=1:
  - write-back handshake at T+2
  - FSM enters FIN at T+3
  - op_done pulses at T+3
  - busy low and start accepted again from T+4
- Sustained throughput is one write-back per cycle while wb_ready=1.

## Test plan
- **Single lane:** nb_lanes_in=0, opcode 6'h05, done0 at T+3 with vd0=64'hDEAD_BEEF, regi0=10'd7, wb_ready=1 → run0 high T+1..T+3, wb at T+4 (idx 7, data DEAD_BEEF, lane 0), op_done at T+5, run1..3 never high.
- **Simultaneous dones:** nb_lanes_in=3, all four dones in the same cycle, rr_ptr=0 → four consecutive handshakes in lane order 0,1,2,3, op_done the cycle after the last.
- **Backpressure:** two lanes done, wb_ready=0 for 5 cycles → wb_valid held, wb_data/wb_idx/wb_lane constant, no loss; after release, both drain in round-robin order.
- **Spurious inputs:** nb_lanes_in=1, done2 pulsed and done0 pulsed twice → exactly two write-backs (lanes 0 and 1); done2 ignored; start pulsed while busy ignored.
- **Round-robin wrap:** after an operation whose last grant was lane 2, run a 4-lane operation with all dones together → grant order 3,0,1,2.
- **Async reset mid-operation:** resetn low during RUN with hvalid set → run, wb_valid and busy drop immediately, no op_done; a new start after reset completes normally.
